// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the receive-side signals between the RX pin, the UART receiver and
//   the byte consumer.
//
//   rx         serial line, idle high, asynchronous to clk
//   data       last correctly framed byte, held until the next good byte
//   valid      one-cycle pulse: data updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       receiver is inside a frame
//
//   master : the receiver (consumes rx, produces the byte stream)
//   slave  : the line driver / consumer side
// ----------------------------------------------------------------------------
interface uart_receiver_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport master (input rx, output data, output valid, output frame_err, output busy);
   modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   8N1 serial-to-parallel UART receiver, LSB first. The rx line is passed
//   through a two-flop synchronizer; start and stop bits are validated and
//   each good byte is presented on bus.data with a one-cycle bus.valid pulse.
//   A low stop bit raises a one-cycle bus.frame_err pulse instead and the byte
//   is dropped; a line held low afterwards yields no further pulses.
//
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   bus        uart_receiver_if.master (rx in; data/valid/frame_err/busy out)
//
//   clk_freq   system clock frequency in Hz
//   baudrate   line rate in bit/s
// ----------------------------------------------------------------------------
module uart_receiver #(
   parameter int clk_freq = 50_000_000,
   parameter int baudrate = 9600
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_receiver_if.master bus
);

   localparam int period = clk_freq / baudrate;
   localparam int half   = period / 2;
   localparam int cnt_w  = (period > 1) ? $clog2(period) : 1;

   localparam logic [cnt_w-1:0] half_last = cnt_w'(half - 1);
   localparam logic [cnt_w-1:0] bit_last  = cnt_w'(period - 1);

   generate
      if (period < 4) begin : g_bad_period
         $error("uart_receiver: clk_freq/baudrate must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_meta, rx_s;

   // NOTE: every register, including the two synchronizer flops (reset to the
   // idle-high line level), is reset asynchronously and assigned with <= only;
   // blocking assignments here would make simulation order-dependent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta   <= bus.rx;
         rx_s      <= rx_meta;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // Sampling points: START samples half a bit in, so every later sample taken
   // a full period apart lands in the middle of its bit.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q + cnt_w'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == half_last) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A start bit that has gone high again by mid-bit was a glitch.
               state_d   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == bit_last) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Returning to IDLE mid-stop-bit lets a back-to-back start edge
            // be caught right at the end of the stop bit.
            if (cnt_q == bit_last) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            // Wait out a held-low line so it reports only one framing error.
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
